// File: rtl/tx_test_sequencer_pkg.sv
// Shared types and constants for the tx test sequencer.
// The state encoding is pinned to 3 bits so it lines up with existing state debug buses.
package tx_test_pkg;

  localparam int SEG_W      = 16;
  localparam int CNT_W      = 32;
  localparam int BYTE_IDX_W = 10;
  localparam int TMR_W      = 16;

  localparam logic [7:0] FILL_BYTE_DEF = 8'h12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP      = 3'd3,
    ST_RGAP     = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  // A zero segment count still means one packet per round.
  function automatic logic [SEG_W-1:0] seg_max_norm(input logic [SEG_W-1:0] v);
    return (v == '0) ? SEG_W'(1) : v;
  endfunction

endpackage

// File: rtl/tx_test_sequencer_if.sv
// MAC tx byte interface between the sequencer (master) and the MAC (slave).
interface tx_test_sequencer_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_en, output tx_data, input tx_ready);
  modport slave  (input tx_en, input tx_data, output tx_ready);
endinterface

// File: rtl/tx_test_sequencer_gap_timer.sv
// Loadable down-counter with a zero flag; times both the packet gap and the round gap.
module gap_timer
  import tx_test_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/tx_test_sequencer.sv
// Transmit test traffic sequencer: rounds of fixed-size packets, aux byte bumped once per round.
// Define DROP_INJECT_EN to add the packet-suppression inputs used for receiver loss testing.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_RDY  | waiting for tx_ready before the next packet
// SEND      | driving packet bytes (or a suppressed packet slot)
// GAP       | idle between packets of a round
// RGAP      | idle after the last packet of a round
// FINISH    | one-cycle done pulse
module tx_test_sequencer
  import tx_test_pkg::*;
#(
  parameter int unsigned PACKETSIZE  = 33,
  parameter int unsigned WHEREIS_AUX = 0,
  parameter int unsigned GAP_CYCLES  = 10,
  parameter int unsigned ROUND_GAP   = 3,
  parameter logic [7:0]  FILL_BYTE   = FILL_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SEG_W-1:0]  segment_number_max,
  input  logic [SEG_W-1:0]  aux_rounds,
`ifdef DROP_INJECT_EN
  input  logic [7:0]        drop_aux,
  input  logic [SEG_W-1:0]  drop_seg_lo,
  input  logic [SEG_W-1:0]  drop_seg_hi,
  input  logic [0:0]        drop_arm,
`endif
  tx_test_sequencer_if.master tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        aux_cnt,
  output logic [SEG_W-1:0]  seg_cnt,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(PACKETSIZE - 1);
  localparam logic [BYTE_IDX_W-1:0] AUX_IDX   = BYTE_IDX_W'(WHEREIS_AUX);
  // The gap state itself covers every idle cycle, so the timer loads N-1 to last N cycles.
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] RGAP_LOAD = TMR_W'(GAP_CYCLES + ROUND_GAP - 1);

  state_e                 state_q, state_d;
  logic [BYTE_IDX_W-1:0]  byte_q, byte_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [7:0]             aux_q, aux_d;
  logic [SEG_W-1:0]       round_q, round_d;
  logic [CNT_W-1:0]       pkt_q, pkt_d;
  logic [SEG_W-1:0]       seg_max_q, seg_max_d;
  logic [SEG_W-1:0]       rounds_q, rounds_d;
  logic                   stop_req_q, stop_req_d;
  logic                   drop_q, drop_d;
  logic                   tx_en_q, tx_en_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_val;
  logic                   tmr_expired;
  logic                   start_pkt;
  logic                   stop_pend;

  gap_timer u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    seg_d      = seg_q;
    aux_d      = aux_q;
    round_d    = round_q;
    pkt_d      = pkt_q;
    seg_max_d  = seg_max_q;
    rounds_d   = rounds_q;
    stop_req_d = stop_req_q;
    drop_d     = drop_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    start_pkt  = 1'b0;
    stop_pend  = stop_req_q | stop;

    if (state_q != ST_IDLE && stop) begin
      stop_req_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_WAIT_RDY;
          aux_d      = '0;
          seg_d      = '0;
          pkt_d      = '0;
          round_d    = '0;
          seg_max_d  = seg_max_norm(segment_number_max);
          rounds_d   = aux_rounds;
          stop_req_d = 1'b0;
        end
      end
      ST_WAIT_RDY: begin
        if (stop_pend) begin
          state_d = ST_FINISH;
        end else if (tx.tx_ready) begin
          start_pkt = 1'b1;
        end
      end
      ST_SEND: begin
        if (byte_q == LAST_BYTE) begin
          if (!drop_q && pkt_q != '1) begin
            pkt_d = pkt_q + 32'd1;
          end
          tmr_load = 1'b1;
          if (seg_q == seg_max_q - 16'd1) begin
            state_d = ST_RGAP;
            tmr_val = RGAP_LOAD;
          end else begin
            state_d = ST_GAP;
            tmr_val = GAP_LOAD;
          end
        end else begin
          byte_d = byte_q + 10'd1;
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          seg_d = seg_q + 16'd1;
          if (stop_pend) begin
            state_d = ST_FINISH;
          end else if (tx.tx_ready) begin
            start_pkt = 1'b1;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_RGAP: begin
        if (tmr_expired) begin
          seg_d   = '0;
          aux_d   = aux_q + 8'd1;
          round_d = round_q + 16'd1;
          if (stop_pend || (rounds_q != '0 && round_d == rounds_q)) begin
            state_d = ST_FINISH;
          end else if (tx.tx_ready) begin
            start_pkt = 1'b1;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is sampled here only, so a packet once started always runs to its full length.
    if (start_pkt) begin
      state_d = ST_SEND;
      byte_d  = '0;
`ifdef DROP_INJECT_EN
      drop_d  = drop_arm[0] && (aux_d == drop_aux) &&
                (seg_d >= drop_seg_lo) && (seg_d <= drop_seg_hi);
`else
      drop_d  = 1'b0;
`endif
    end

    tx_en_d   = (state_d == ST_SEND) && !drop_d;
    tx_data_d = tx_en_d ? ((byte_d == AUX_IDX) ? aux_d : FILL_BYTE) : 8'h00;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      seg_q      <= '0;
      aux_q      <= '0;
      round_q    <= '0;
      pkt_q      <= '0;
      seg_max_q  <= '0;
      rounds_q   <= '0;
      stop_req_q <= 1'b0;
      drop_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      seg_q      <= seg_d;
      aux_q      <= aux_d;
      round_q    <= round_d;
      pkt_q      <= pkt_d;
      seg_max_q  <= seg_max_d;
      rounds_q   <= rounds_d;
      stop_req_q <= stop_req_d;
      drop_q     <= drop_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx.tx_en   = tx_en_q;
  assign tx.tx_data = tx_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aux_cnt    = aux_q;
  assign seg_cnt    = seg_q;
  assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_tx_test_sequencer.sv
// Directed bench for tx_test_sequencer with default parameters (33-byte packets, aux at byte 0).
// A negedge monitor logs each packet; scenario tasks compare the log against hand-derived values.
module tb_tx_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] seg_max_in = 16'd0;
  logic [15:0] rounds_in = 16'd0;
  logic        busy, done;
  logic [7:0]  aux_cnt;
  logic [15:0] seg_cnt;
  logic [31:0] pkt_count;
`ifdef DROP_INJECT_EN
  logic [7:0]  drop_aux = 8'd0;
  logic [15:0] drop_seg_lo = 16'd0;
  logic [15:0] drop_seg_hi = 16'd0;
  logic [0:0]  drop_arm = 1'b0;
`endif

  tx_test_sequencer_if tx ();

  tx_test_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .segment_number_max (seg_max_in),
    .aux_rounds         (rounds_in),
`ifdef DROP_INJECT_EN
    .drop_aux           (drop_aux),
    .drop_seg_lo        (drop_seg_lo),
    .drop_seg_hi        (drop_seg_hi),
    .drop_arm           (drop_arm),
`endif
    .tx                 (tx),
    .busy               (busy),
    .done               (done),
    .aux_cnt            (aux_cnt),
    .seg_cnt            (seg_cnt),
    .pkt_count          (pkt_count)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         q_start[$];
  int         q_len[$];
  int         q_bad[$];
  logic [7:0] q_aux[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         idle_nz = 0;
  bit         in_pkt = 1'b0;
  int         cur_len = 0;
  int         cur_bad = 0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx.tx_en === 1'b1) begin
      if (!in_pkt) begin
        in_pkt  = 1'b1;
        cur_len = 0;
        cur_bad = 0;
        q_start.push_back(cyc);
      end
      if (cur_len == 0) q_aux.push_back(tx.tx_data);
      else if (tx.tx_data !== 8'h12) cur_bad++;
      cur_len++;
    end else begin
      if (tx.tx_data !== 8'h00) idle_nz++;
      if (in_pkt) begin
        in_pkt = 1'b0;
        q_len.push_back(cur_len);
        q_bad.push_back(cur_bad);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_start.delete();
    q_len.delete();
    q_bad.delete();
    q_aux.delete();
    done_cnt = 0;
    idle_nz  = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required a done pulse", name, budget);
    end
    tick();
    tick();
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k = 0;
    while (q_start.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (q_start.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: %0d packets started, required %0d", name, q_start.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx.tx_en, tx.tx_data, busy, done, aux_cnt, seg_cnt, pkt_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tx_en=%b tx_data=%h busy=%b done=%b aux=%0d seg=%0d pkt=%0d, required all 0",
               tx.tx_en, tx.tx_data, busy, done, aux_cnt, seg_cnt, pkt_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_run(input string tag);
    int s, n, g, nb_len = 0, nb_aux = 0, nb_gap = 0, nb_fill = 0;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd3;
    s = cyc;
    pulse_start();
    wait_pkts(2, 200, tag);
    seg_max_in = 16'd5;
    rounds_in  = 16'd1;
    pulse_start();
    wait_done(10000, tag);
    seg_max_in = 16'd50;
    rounds_in  = 16'd3;
    checks++;
    if (q_start.size() == 0 || q_start[0] - s != 2) begin
      errors++;
      $display("FAIL %s_latency: first tx_en %0d cycles after start, required 2", tag,
               (q_start.size() > 0) ? q_start[0] - s : -1);
    end
    n = q_len.size();
    for (int i = 0; i < n; i++) begin
      if (q_len[i] != 33) nb_len++;
      if (q_aux[i] != 8'(i / 50)) nb_aux++;
      nb_fill += q_bad[i];
      if (i + 1 < n) begin
        g = q_start[i+1] - q_start[i] - q_len[i];
        if (g != (((i + 1) % 50 == 0) ? 13 : 10)) nb_gap++;
      end
    end
    checks++;
    if (n != 150) begin errors++; $display("FAIL %s_pkts: packets %0d, required 150", tag, n); end
    checks++;
    if (nb_len != 0) begin errors++; $display("FAIL %s_len: %0d packets not 33 bytes, required 0", tag, nb_len); end
    checks++;
    if (nb_aux != 0) begin errors++; $display("FAIL %s_aux: %0d wrong aux bytes, required 0", tag, nb_aux); end
    checks++;
    if (nb_fill != 0 || idle_nz != 0) begin
      errors++;
      $display("FAIL %s_data: %0d bad fill bytes, %0d nonzero idle bytes, required 0 and 0", tag, nb_fill, idle_nz);
    end
    checks++;
    if (nb_gap != 0) begin errors++; $display("FAIL %s_gaps: %0d wrong gaps, required 0", tag, nb_gap); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done: %0d done pulses, required 1", tag, done_cnt); end
    checks++;
    if (pkt_count !== 32'd150 || busy !== 1'b0 || aux_cnt !== 8'd3) begin
      errors++;
      $display("FAIL %s_final: pkt_count=%0d busy=%b aux_cnt=%0d, required 150 0 3", tag, pkt_count, busy, aux_cnt);
    end
  endtask

  task automatic test_stall();
    int k = 0, en_seen = 0, r, q5;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd0;
    pulse_start();
    while (pkt_count < 32'd5 && k < 1000) begin tick(); k++; end
    tx.tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx.tx_en === 1'b1) en_seen++;
    end
    r = cyc;
    tx.tx_ready = 1'b1;
    wait_pkts(6, 50, "stall");
    q5 = (q_start.size() > 5) ? q_start[5] : -1;
    checks++;
    if (en_seen != 0) begin errors++; $display("FAIL stall_quiet: tx_en high %0d cycles during stall, required 0", en_seen); end
    checks++;
    if (q5 != r + 1) begin errors++; $display("FAIL stall_resume: packet 5 at cycle %0d, required %0d", q5, r + 1); end
    while (cyc < q5 + 5) tick();
    tx.tx_ready = 1'b0;
    tick(); tick(); tick();
    tx.tx_ready = 1'b1;
    k = 0;
    while (q_len.size() < 6 && k < 100) begin tick(); k++; end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (q_len.size() < 6 || q_len[5] != 33) begin
      errors++;
      $display("FAIL stall_untruncated: packet 5 length %0d, required 33", (q_len.size() > 5) ? q_len[5] : -1);
    end
    wait_done(100, "stall");
    checks++;
    if (pkt_count !== 32'd6) begin errors++; $display("FAIL stall_count: pkt_count=%0d, required 6", pkt_count); end
  endtask

  task automatic test_stop();
    int p;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd0;
    pulse_start();
    wait_pkts(8, 1000, "stop");
    p = (q_start.size() > 7) ? q_start[7] : cyc;
    while (cyc < p + 10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(200, "stop");
    checks++;
    if (done_cyc != p + 43) begin errors++; $display("FAIL stop_done_time: done at %0d, required %0d", done_cyc, p + 43); end
    checks++;
    if (q_len.size() != 8 || q_len[7] != 33) begin
      errors++;
      $display("FAIL stop_pkts: %0d packets, last length %0d, required 8 and 33", q_len.size(),
               (q_len.size() > 0) ? q_len[q_len.size()-1] : -1);
    end
    checks++;
    if (pkt_count !== 32'd8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_final: pkt_count=%0d busy=%b, required 8 0", pkt_count, busy);
    end
  endtask

  task automatic test_start_stop_same();
    clear_log();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy !== 1'b0 || q_start.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL start_stop_same: busy=%b packets=%0d done=%0d, required 0 0 0", busy, q_start.size(), done_cnt);
    end
  endtask

  task automatic test_stop_wait_rdy();
    int s;
    clear_log();
    tx.tx_ready = 1'b0;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd0;
    pulse_start();
    tick();
    s = cyc;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(20, "stop_wait_rdy");
    checks++;
    if (done_cyc != s + 1 || q_start.size() != 0 || pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL stop_wait_rdy: done at %0d packets=%0d pkt_count=%0d, required %0d 0 0",
               done_cyc, q_start.size(), pkt_count, s + 1);
    end
    tx.tx_ready = 1'b1;
  endtask

  task automatic test_seg_zero();
    int g;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd0;
    rounds_in   = 16'd2;
    pulse_start();
    wait_done(300, "seg_zero");
    g = (q_len.size() == 2) ? q_start[1] - q_start[0] - q_len[0] : -1;
    checks++;
    if (q_len.size() != 2 || g != 13 || q_aux[1] !== 8'd1 || pkt_count !== 32'd2) begin
      errors++;
      $display("FAIL seg_zero: packets=%0d gap=%0d pkt_count=%0d, required 2 13 2", q_len.size(), g, pkt_count);
    end
  endtask

  task automatic test_aux_wrap();
    int n, nb_aux = 0, nb_gap = 0;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd1;
    rounds_in   = 16'd258;
    pulse_start();
    wait_done(15000, "aux_wrap");
    n = q_len.size();
    for (int i = 0; i < n; i++) begin
      if (q_aux[i] != 8'(i % 256)) nb_aux++;
      if (i + 1 < n && q_start[i+1] - q_start[i] - q_len[i] != 13) nb_gap++;
    end
    checks++;
    if (n != 258 || done_cnt != 1) begin
      errors++;
      $display("FAIL aux_wrap_pkts: packets=%0d done=%0d, required 258 1", n, done_cnt);
    end
    checks++;
    if (n == 258 && {q_aux[254], q_aux[255], q_aux[256], q_aux[257]} !== {8'd254, 8'd255, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL aux_wrap_seq: aux %0d %0d %0d %0d, required 254 255 0 1", q_aux[254], q_aux[255], q_aux[256], q_aux[257]);
    end
    checks++;
    if (nb_aux != 0 || nb_gap != 0) begin
      errors++;
      $display("FAIL aux_wrap_all: %0d wrong aux, %0d wrong gaps, required 0 0", nb_aux, nb_gap);
    end
    checks++;
    if (pkt_count !== 32'd258 || aux_cnt !== 8'd2) begin
      errors++;
      $display("FAIL aux_wrap_final: pkt_count=%0d aux_cnt=%0d, required 258 2", pkt_count, aux_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd3;
    pulse_start();
    wait_pkts(1, 50, "reset_mid");
    p = (q_start.size() > 0) ? q_start[0] : cyc;
    while (cyc < p + 20) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx.tx_en !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_en: tx_en=%b, required 0", tx.tx_en); end
    checks++;
    if ({tx.tx_data, busy, done, aux_cnt, seg_cnt, pkt_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: tx_data=%h busy=%b done=%b aux=%0d seg=%0d pkt=%0d, required all 0",
               tx.tx_data, busy, done, aux_cnt, seg_cnt, pkt_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_full_run("rerun");
  endtask

`ifdef DROP_INJECT_EN
  task automatic test_drop();
    int n, j, nb = 0;
    clear_log();
    tx.tx_ready = 1'b1;
    seg_max_in  = 16'd50;
    rounds_in   = 16'd16;
    drop_aux    = 8'd12;
    drop_seg_lo = 16'd7;
    drop_seg_hi = 16'd8;
    drop_arm    = 1'b1;
    pulse_start();
    wait_done(40000, "drop");
    drop_arm = 1'b0;
    n = q_len.size();
    for (int k = 0; k < n; k++) begin
      j = (k < 607) ? k : k + 2;
      if (q_start[k] - q_start[0] != j * 43 + (j / 50) * 3) nb++;
      if (q_aux[k] != 8'(j / 50) || q_len[k] != 33) nb++;
    end
    checks++;
    if (n != 798 || pkt_count !== 32'd798) begin
      errors++;
      $display("FAIL drop_count: packets=%0d pkt_count=%0d, required 798 798", n, pkt_count);
    end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL drop_timing: %0d packets off schedule, required 0", nb); end
  endtask
`endif

  initial begin
    tx.tx_ready = 1'b1;
    test_reset();
    test_full_run("full");
    test_stall();
    test_stop();
    test_start_stop_same();
    test_stop_wait_rdy();
    test_seg_zero();
    test_aux_wrap();
    test_reset_mid();
`ifdef DROP_INJECT_EN
    test_drop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
